// File: rtl/snake_shift_if.sv
// Command/status bundle between the button front-end, snake_shift_ctrl and digit_store.
// master drives buttons/start/hit/pause; slave (the controller) drives load/shift/status.
interface snake_shift_if;
   logic       start;
   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic       hit;
   logic       pause;
   logic       set;
   logic [2:0] user_input;
   logic       up_shift;
   logic       down_shift;
   logic       left_shift;
   logic       right_shift;
   logic [1:0] dir;
   logic       running;
   logic       game_over;

   modport master (
      output start, btn_up, btn_down, btn_left, btn_right, hit, pause,
      input  set, user_input, up_shift, down_shift, left_shift, right_shift, dir, running,
             game_over
   );

   modport slave (
      input  start, btn_up, btn_down, btn_left, btn_right, hit, pause,
      output set, user_input, up_shift, down_shift, left_shift, right_shift, dir, running,
             game_over
   );
endinterface

// File: rtl/snake_shift_ctrl.sv
// Game-tick driver for digit_store: load pulse, one-hot shift pulses, direction and game state.
// Optional SNAKE_PAUSE_EN: pause freezes the move counter while running.
module snake_shift_ctrl #(
   parameter int unsigned TICK_DIV  = 16,
   parameter logic [2:0]  START_PAT = 3'b111,
   parameter logic [1:0]  START_DIR = 2'd0
) (
   input logic          clk,
   input logic          reset,
   snake_shift_if.slave bus
);

   localparam int unsigned CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StOver} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    dir_q, dir_d;
   logic [1:0]    pend_q, pend_d;
   logic          pend_vld_q, pend_vld_d;
   logic          tick_q, tick_d;
   logic          start_q;
   logic [3:0]    btn_q;
   logic [3:0]    shift_q, shift_d;
   logic          set_q, running_q, game_over_q;
   logic [2:0]    user_input_q;

   logic       start_edge, frz, tick, req_vld;
   logic [3:0] btn_now, btn_edge;
   logic [1:0] req_dir;

   assign btn_now    = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
   assign btn_edge   = btn_now & ~btn_q;
   assign start_edge = bus.start & ~start_q;

`ifdef SNAKE_PAUSE_EN
   assign frz = (state_q == StRun) && bus.pause;
`else
   assign frz = 1'b0;
`endif

   assign tick = (state_q == StRun) && (cnt_q == CNT_MAX) && !frz;

   always_comb begin
      req_dir = DIR_RIGHT;
      if (btn_edge[0])      req_dir = DIR_UP;
      else if (btn_edge[1]) req_dir = DIR_DOWN;
      else if (btn_edge[2]) req_dir = DIR_LEFT;
   end

   // Reversals differ from the current direction only in bit 0.
   assign req_vld = (|btn_edge) && (state_q != StOver) && ((req_dir ^ dir_q) != 2'b01);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dir_d      = dir_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      tick_d     = 1'b0;
      if (req_vld) begin
         pend_d     = req_dir;
         pend_vld_d = 1'b1;
      end
      unique case (state_q)
         StIdle, StOver: begin
            if (start_edge) begin
               state_d = StLoad;
               dir_d   = START_DIR;
               cnt_d   = '0;
            end
         end
         StLoad: begin
            state_d = StRun;
            cnt_d   = '0;
         end
         StRun: begin
            if (!frz) cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
            if (tick) begin
               pend_vld_d = 1'b0;
               if (bus.hit) begin
                  state_d = StOver;
               end else begin
                  tick_d = 1'b1;
                  if (req_vld)         dir_d = req_dir;
                  else if (pend_vld_q) dir_d = pend_q;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Shift fires the cycle after the tick so it uses the freshly applied direction.
   assign shift_d = (tick_q && state_q == StRun) ? (4'b0001 << dir_q) : 4'b0000;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         dir_q        <= START_DIR;
         pend_q       <= DIR_UP;
         pend_vld_q   <= 1'b0;
         tick_q       <= 1'b0;
         start_q      <= 1'b0;
         btn_q        <= 4'b0000;
         shift_q      <= 4'b0000;
         set_q        <= 1'b0;
         user_input_q <= 3'b000;
         running_q    <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         dir_q        <= dir_d;
         pend_q       <= pend_d;
         pend_vld_q   <= pend_vld_d;
         tick_q       <= tick_d;
         start_q      <= bus.start;
         btn_q        <= btn_now;
         shift_q      <= shift_d;
         set_q        <= (state_d == StLoad);
         user_input_q <= (state_d == StLoad) ? START_PAT : 3'b000;
         running_q    <= (state_d == StRun);
         game_over_q  <= (state_d == StOver);
      end
   end

   assign bus.set         = set_q;
   assign bus.user_input  = user_input_q;
   assign bus.up_shift    = shift_q[0];
   assign bus.down_shift  = shift_q[1];
   assign bus.left_shift  = shift_q[2];
   assign bus.right_shift = shift_q[3];
   assign bus.dir         = dir_q;
   assign bus.running     = running_q;
   assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_snake_shift_ctrl.sv
// Scoreboard bench for snake_shift_ctrl (TICK_DIV=4): stimulus queues expected load/shift events
// with their cycle stamps; a monitor pops and compares whenever set or a shift output is high.
module tb_snake_shift_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int unsigned cyc = 0;
   int n_pass = 0;
   int n_total = 0;

   localparam logic [7:0] EV_SET   = 8'b1111_0000;
   localparam logic [7:0] EV_UP    = 8'b0000_0001;
   localparam logic [7:0] EV_RIGHT = 8'b0000_1000;

   typedef struct packed {
      int unsigned at;
      logic [7:0]  ev;
   } exp_t;

   exp_t exp_q[$];
   int unsigned s, r, p;

   snake_shift_if bus_if ();

   snake_shift_ctrl #(
      .TICK_DIV (4),
      .START_PAT(3'b111),
      .START_DIR(2'd0)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
   endtask

   task automatic push(input int unsigned at, input logic [7:0] ev);
      exp_t e;
      e.at = at;
      e.ev = ev;
      exp_q.push_back(e);
   endtask

   task automatic wait_to(input int unsigned c);
      while (cyc < c) @(negedge clk);
   endtask

   // Monitor: any load or shift pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      logic [7:0] ev;
      exp_t e;
      ev = {bus_if.set, bus_if.user_input, bus_if.right_shift, bus_if.left_shift,
            bus_if.down_shift, bus_if.up_shift};
      if (ev != 8'h00) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_event: got %b at cycle %0d, expected none", ev, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("event_value", int'(ev), int'(e.ev));
            chk("event_cycle", int'(cyc), int'(e.at));
         end
      end
   end

   initial begin
      bus_if.start = 0; bus_if.btn_up = 0; bus_if.btn_down = 0; bus_if.btn_left = 0;
      bus_if.btn_right = 0; bus_if.hit = 0; bus_if.pause = 0;
      repeat (3) @(negedge clk);
      chk("rst_outs", int'({bus_if.set, bus_if.user_input, bus_if.up_shift, bus_if.down_shift,
                            bus_if.left_shift, bus_if.right_shift, bus_if.running,
                            bus_if.game_over}), 0);
      chk("rst_dir", int'(bus_if.dir), 0);
      reset = 1;
      @(negedge clk);

      // Start, up shifts, right turn, discarded reversal, simultaneous up+left.
      s = cyc;
      bus_if.start = 1;
      push(s + 1, EV_SET);   push(s + 7, EV_UP);     push(s + 11, EV_UP);
      push(s + 15, EV_RIGHT); push(s + 19, EV_RIGHT); push(s + 23, EV_RIGHT);
      push(s + 27, EV_UP);   push(s + 31, EV_UP);
      wait_to(s + 1);  chk("load_running", int'(bus_if.running), 0); bus_if.start = 0;
      wait_to(s + 2);  chk("run_running", int'(bus_if.running), 1);
      wait_to(s + 12); bus_if.btn_right = 1;
      wait_to(s + 13); chk("dir_before_tick", int'(bus_if.dir), 0);
      wait_to(s + 14); chk("dir_right", int'(bus_if.dir), 3);
      wait_to(s + 15); bus_if.btn_right = 0;
      wait_to(s + 16); bus_if.btn_left = 1;
      wait_to(s + 20); chk("dir_reverse_discard", int'(bus_if.dir), 3);
      wait_to(s + 21); bus_if.btn_left = 0;
      wait_to(s + 23); bus_if.btn_up = 1; bus_if.btn_left = 1;
      wait_to(s + 25); chk("dir_hold_until_tick", int'(bus_if.dir), 3);
      wait_to(s + 26); chk("dir_up_priority", int'(bus_if.dir), 0);
      bus_if.btn_up = 0; bus_if.btn_left = 0;
      wait_to(s + 28); bus_if.start = 1;
      wait_to(s + 29); bus_if.start = 0; chk("start_in_run_ignored", int'(bus_if.running), 1);

      // Hit held across non-tick cycles, then sampled at the tick.
      wait_to(s + 31); bus_if.hit = 1;
      wait_to(s + 33); chk("hit_off_tick_ignored", int'(bus_if.running), 1);
      wait_to(s + 34);
      chk("hit_game_over", int'(bus_if.game_over), 1);
      chk("hit_running", int'(bus_if.running), 0);
      bus_if.hit = 0;
      wait_to(s + 40); chk("over_hold", int'(bus_if.game_over), 1);

      // Restart from OVER, turn right, then reset with a shift pulse in flight.
      r = cyc;
      bus_if.start = 1;
      push(r + 1, EV_SET); push(r + 7, EV_UP); push(r + 11, EV_RIGHT);
      wait_to(r + 1);  chk("restart_over_clear", int'(bus_if.game_over), 0); bus_if.start = 0;
      wait_to(r + 8);  bus_if.btn_right = 1;
      wait_to(r + 12); bus_if.btn_right = 0;
      wait_to(r + 14); chk("pre_reset_dir", int'(bus_if.dir), 3);
      reset = 0;
      #1;
      chk("async_reset_dir", int'(bus_if.dir), 0);
      chk("async_reset_outs", int'({bus_if.set, bus_if.running, bus_if.game_over,
                                    bus_if.up_shift, bus_if.right_shift}), 0);
      wait_to(r + 16); reset = 1;
      wait_to(r + 30);
      chk("idle_after_reset", int'({bus_if.running, bus_if.game_over}), 0);

      // Pause held 10 clocks in RUN: freezes the counter only when the feature is built in.
      p = cyc;
      bus_if.start = 1;
      push(p + 1, EV_SET); push(p + 7, EV_UP);
`ifdef SNAKE_PAUSE_EN
      push(p + 21, EV_UP); push(p + 25, EV_UP);
`else
      push(p + 11, EV_UP); push(p + 15, EV_UP); push(p + 19, EV_UP); push(p + 23, EV_UP);
`endif
      wait_to(p + 1);  bus_if.start = 0;
      wait_to(p + 8);  bus_if.pause = 1;
      wait_to(p + 13); chk("pause_running", int'(bus_if.running), 1);
      wait_to(p + 18); bus_if.pause = 0;
      wait_to(p + 26); reset = 0;
      repeat (4) @(negedge clk);
      reset = 1;
      repeat (6) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
